// File: rtl/b01_outp_collector.sv
// b01_outp_collector
// Collects the serial OUTP/OVERFLW stream of the b01 flow comparator and packs
// OUTP LSB-first into WIDTH-bit words. Finished (or flushed) words move into a
// one-entry valid/ready output buffer that drains at the consumer's pace.
// Optional feature macro: B01_OVF_COUNT_EN adds a saturating counter of
// OVERFLW rising events on OVF_CNT; without it OVF_CNT is tied to 0.
module b01_outp_collector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         outp_i,
    input  logic                         overflw_i,
    input  logic                         bit_en_i,
    input  logic                         flush_i,
    output logic [WIDTH-1:0]             word_data_o,
    output logic [$clog2(WIDTH+1)-1:0]   word_len_o,
    output logic                         word_ovf_o,
    output logic                         word_valid_o,
    input  logic                         word_ready_i,
    output logic                         drop_o,
    output logic [CNT_W-1:0]             ovf_cnt_o
);

    localparam int LEN_W = $clog2(WIDTH+1);
    localparam logic [LEN_W-1:0] FULL_CNT = LEN_W'(WIDTH);

    // FILL: collecting bits (cnt < WIDTH); HOLD: complete word waiting for the buffer
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] asmData_q, asmData_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             stickyOvf_q, stickyOvf_d;
    logic             flushPend_q, flushPend_d;

    logic [WIDTH-1:0] bufData_q, bufData_d;
    logic [LEN_W-1:0] bufLen_q, bufLen_d;
    logic             bufOvf_q, bufOvf_d;
    logic             bufValid_q, bufValid_d;
    logic             drop_q, drop_d;

    logic             bufFree;
    logic             flushReq;
    logic [WIDTH-1:0] addData;
    logic [LEN_W-1:0] addCnt;
    logic             addOvf;
    logic             doMove;
    logic [WIDTH-1:0] moveData;
    logic [LEN_W-1:0] moveLen;
    logic             moveOvf;

    // Next-state logic: fold in this cycle's bit, then decide whether the word moves out
    always_comb begin
        bufFree  = !bufValid_q || word_ready_i;
        flushReq = flush_i || flushPend_q;

        addData = asmData_q;
        addCnt  = cnt_q;
        addOvf  = stickyOvf_q;
        if (bit_en_i && (state_q == ST_FILL)) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (cnt_q == LEN_W'(i)) begin
                    addData[i] = outp_i;
                end
            end
            addCnt = cnt_q + LEN_W'(1);
            addOvf = stickyOvf_q | overflw_i;
        end

        state_d     = state_q;
        asmData_d   = asmData_q;
        cnt_d       = cnt_q;
        stickyOvf_d = stickyOvf_q;
        flushPend_d = flushPend_q;
        drop_d      = 1'b0;
        doMove      = 1'b0;
        moveData    = addData;
        moveLen     = addCnt;
        moveOvf     = addOvf;

        case (state_q)
            ST_FILL: begin
                doMove = bufFree &&
                         ((addCnt == FULL_CNT) || (flushReq && (addCnt != '0)));
                if (doMove) begin
                    asmData_d   = '0;
                    cnt_d       = '0;
                    stickyOvf_d = 1'b0;
                    flushPend_d = 1'b0;
                end else begin
                    asmData_d   = addData;
                    cnt_d       = addCnt;
                    stickyOvf_d = addOvf;
                    flushPend_d = flushReq && (addCnt != '0);
                    state_d     = (addCnt == FULL_CNT) ? ST_HOLD : ST_FILL;
                end
            end
            ST_HOLD: begin
                // A flush here is satisfied by the held word itself
                flushPend_d = 1'b0;
                moveData    = asmData_q;
                moveLen     = cnt_q;
                moveOvf     = stickyOvf_q;
                if (bufFree) begin
                    doMove  = 1'b1;
                    state_d = ST_FILL;
                    if (bit_en_i) begin
                        asmData_d   = {{(WIDTH-1){1'b0}}, outp_i};
                        cnt_d       = LEN_W'(1);
                        stickyOvf_d = overflw_i;
                    end else begin
                        asmData_d   = '0;
                        cnt_d       = '0;
                        stickyOvf_d = 1'b0;
                    end
                end else begin
                    drop_d = bit_en_i;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        bufData_d  = bufData_q;
        bufLen_d   = bufLen_q;
        bufOvf_d   = bufOvf_q;
        bufValid_d = bufValid_q;
        if (doMove) begin
            bufData_d  = moveData;
            bufLen_d   = moveLen;
            bufOvf_d   = moveOvf;
            bufValid_d = 1'b1;
        end else if (word_ready_i) begin
            bufValid_d = 1'b0;
        end
    end

    // State, assembly and output buffer registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_FILL;
            asmData_q   <= '0;
            cnt_q       <= '0;
            stickyOvf_q <= 1'b0;
            flushPend_q <= 1'b0;
            bufData_q   <= '0;
            bufLen_q    <= '0;
            bufOvf_q    <= 1'b0;
            bufValid_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            asmData_q   <= asmData_d;
            cnt_q       <= cnt_d;
            stickyOvf_q <= stickyOvf_d;
            flushPend_q <= flushPend_d;
            bufData_q   <= bufData_d;
            bufLen_q    <= bufLen_d;
            bufOvf_q    <= bufOvf_d;
            bufValid_q  <= bufValid_d;
            drop_q      <= drop_d;
        end
    end

    assign word_data_o  = bufData_q;
    assign word_len_o   = bufLen_q;
    assign word_ovf_o   = bufOvf_q;
    assign word_valid_o = bufValid_q;
    assign drop_o       = drop_q;

`ifdef B01_OVF_COUNT_EN
    logic             prevOvf_q;
    logic [CNT_W-1:0] ovfCnt_q;

    // Count OVERFLW 0->1 transitions across sampled bits, saturating at all-ones
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            prevOvf_q <= 1'b0;
            ovfCnt_q  <= '0;
        end else if (bit_en_i) begin
            prevOvf_q <= overflw_i;
            if (overflw_i && !prevOvf_q && (ovfCnt_q != '1)) begin
                ovfCnt_q <= ovfCnt_q + CNT_W'(1);
            end
        end
    end

    assign ovf_cnt_o = ovfCnt_q;
`else
    assign ovf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_b01_outp_collector.sv
// tb_b01_outp_collector
// Self-checking bench: a table of word vectors plus hand-written multi-cycle
// sequences. Expected words go into a queue when driven and are popped when
// the collector hands a word over. Honours B01_OVF_COUNT_EN if defined.
module tb_b01_outp_collector;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(WIDTH+1);

    logic             clock_i;
    logic             reset_i;
    logic             outp_i;
    logic             overflw_i;
    logic             bit_en_i;
    logic             flush_i;
    logic [WIDTH-1:0] word_data_o;
    logic [LEN_W-1:0] word_len_o;
    logic             word_ovf_o;
    logic             word_valid_o;
    logic             word_ready_i;
    logic             drop_o;
    logic [CNT_W-1:0] ovf_cnt_o;

    b01_outp_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .outp_i       (outp_i),
        .overflw_i    (overflw_i),
        .bit_en_i     (bit_en_i),
        .flush_i      (flush_i),
        .word_data_o  (word_data_o),
        .word_len_o   (word_len_o),
        .word_ovf_o   (word_ovf_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .drop_o       (drop_o),
        .ovf_cnt_o    (ovf_cnt_o)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        int               len;
        logic             ovf;
    } word_t;

    typedef struct {
        logic [7:0] bits;
        int         nBits;
        logic [7:0] ovfMask;
        int         flushMode;
        logic [7:0] expData;
        int         expLen;
        logic       expOvf;
    } vec_t;

    word_t expQ[$];
    vec_t  vecs[6];
    word_t popped;
    word_t heldWord;
    logic  monHeld = 1'b0;
    int    testsRun = 0;
    int    testsFailed = 0;
    int    dropSeen = 0;
    int    dropBase;
    int    ovfModel = 0;
    logic  prevOvfModel = 1'b0;

    // Free-running clock, 10 time units per cycle
    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor on the falling edge: pop/compare transfers, check hold stability, count drops
    always @(negedge clock_i) begin
        if (reset_i) begin
            monHeld = 1'b0;
        end else begin
            if (drop_o) dropSeen++;
            if (word_valid_o && word_ready_i) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWord", 1, 0);
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("wordData", int'(word_data_o), int'(popped.data));
                    checkOutput("wordLen", int'(word_len_o), popped.len);
                    checkOutput("wordOvf", int'(word_ovf_o), int'(popped.ovf));
                end
                monHeld = 1'b0;
            end else if (word_valid_o) begin
                if (monHeld) begin
                    checkOutput("holdData", int'(word_data_o), int'(heldWord.data));
                    checkOutput("holdLen", int'(word_len_o), heldWord.len);
                    checkOutput("holdOvf", int'(word_ovf_o), int'(heldWord.ovf));
                end
                heldWord.data = word_data_o;
                heldWord.len  = int'(word_len_o);
                heldWord.ovf  = word_ovf_o;
                monHeld = 1'b1;
            end else begin
                monHeld = 1'b0;
            end
        end
    end

    task automatic pushWord(input logic [7:0] data, input int len, input logic ovf);
        word_t w;
        w.data = data;
        w.len  = len;
        w.ovf  = ovf;
        expQ.push_back(w);
    endtask

    task automatic driveCycle(input logic en, input logic b, input logic ov, input logic fl);
        bit_en_i  = en;
        outp_i    = b;
        overflw_i = ov;
        flush_i   = fl;
        if (en) begin
`ifdef B01_OVF_COUNT_EN
            if (ov && !prevOvfModel && (ovfModel < (1 << CNT_W) - 1)) ovfModel++;
`endif
            prevOvfModel = ov;
        end
        @(posedge clock_i);
        #1;
        bit_en_i  = 1'b0;
        outp_i    = 1'b0;
        overflw_i = 1'b0;
        flush_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) driveCycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic driveWord(input logic [7:0] bits, input logic [7:0] mask, input int n);
        for (int i = 0; i < n; i++) driveCycle(1'b1, bits[i], mask[i], 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v);
        pushWord(v.expData, v.expLen, v.expOvf);
        for (int i = 0; i < v.nBits; i++) begin
            driveCycle(1'b1, v.bits[i], v.ovfMask[i], (v.flushMode == 2) && (i == v.nBits - 1));
        end
        if (v.flushMode == 1) driveCycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
    endtask

    task automatic waitDrain(input int maxCycles);
        int c = 0;
        while ((expQ.size() != 0) && (c < maxCycles)) begin
            @(posedge clock_i);
            #1;
            c++;
        end
        checkOutput("drainQueue", expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic doReset();
        reset_i = 1'b1;
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        expQ.delete();
        ovfModel = 0;
        prevOvfModel = 1'b0;
        checkOutput("rstValid", int'(word_valid_o), 0);
        checkOutput("rstData", int'(word_data_o), 0);
        checkOutput("rstLen", int'(word_len_o), 0);
        checkOutput("rstOvf", int'(word_ovf_o), 0);
        checkOutput("rstDrop", int'(drop_o), 0);
        checkOutput("rstOvfCnt", int'(ovf_cnt_o), 0);
    endtask

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main test sequence
    initial begin
        reset_i = 1'b1;
        outp_i = 1'b0;
        overflw_i = 1'b0;
        bit_en_i = 1'b0;
        flush_i = 1'b0;
        word_ready_i = 1'b1;
        @(posedge clock_i);
        #1;
        doReset();

        vecs[0] = '{8'hE1, 8, 8'h00, 0, 8'hE1, 8, 1'b0};
        vecs[1] = '{8'hA5, 8, 8'h10, 0, 8'hA5, 8, 1'b1};
        vecs[2] = '{8'h3C, 8, 8'h00, 0, 8'h3C, 8, 1'b0};
        vecs[3] = '{8'h07, 3, 8'h00, 1, 8'h07, 3, 1'b0};
        vecs[4] = '{8'h15, 5, 8'h00, 2, 8'h15, 5, 1'b0};
        vecs[5] = '{8'h01, 1, 8'h01, 1, 8'h01, 1, 1'b1};

        $display("[TB] full word latency, bits 1,0,1,1,0,0,1,0");
        pushWord(8'h4D, 8, 1'b0);
        driveWord(8'h4D, 8'h00, 7);
        checkOutput("latencyBefore", int'(word_valid_o), 0);
        driveWord(8'h80, 8'h00, 1);
        checkOutput("latencyValid", int'(word_valid_o), 1);
        checkOutput("latencyData", int'(word_data_o), 'h4D);
        checkOutput("latencyLen", int'(word_len_o), 8);
        waitDrain(10);

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            waitDrain(10);
        end
        driveCycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        checkOutput("flushAloneNoValid", int'(word_valid_o), 0);
        checkOutput("ovfCntTable", int'(ovf_cnt_o), ovfModel);

        $display("[TB] backpressure with 24 bits");
        word_ready_i = 1'b0;
        dropBase = dropSeen;
        pushWord(8'h11, 8, 1'b0);
        pushWord(8'h22, 8, 1'b0);
        driveWord(8'h11, 8'h00, 8);
        driveWord(8'h22, 8'h00, 8);
        driveWord(8'hFF, 8'h00, 8);
        idle(2);
        checkOutput("dropCount", dropSeen - dropBase, 8);
        checkOutput("bufHeldValid", int'(word_valid_o), 1);
        word_ready_i = 1'b1;
        waitDrain(10);
        idle(2);
        checkOutput("afterBackpressureIdle", int'(word_valid_o), 0);

        $display("[TB] reset mid-word");
        dropBase = dropSeen;
        driveWord(8'h1F, 8'h00, 5);
        doReset();
        pushWord(8'hFF, 8, 1'b0);
        driveWord(8'hFF, 8'h00, 8);
        waitDrain(10);
        idle(2);
        checkOutput("resetNoDrop", dropSeen - dropBase, 0);
        checkOutput("resetOneWord", int'(word_valid_o), 0);

        $display("[TB] bit on the cycle the held word moves");
        dropBase = dropSeen;
        word_ready_i = 1'b0;
        pushWord(8'h5A, 8, 1'b0);
        pushWord(8'hC3, 8, 1'b0);
        pushWord(8'h81, 8, 1'b0);
        driveWord(8'h5A, 8'h00, 8);
        driveWord(8'hC3, 8'h00, 8);
        idle(1);
        word_ready_i = 1'b1;
        driveWord(8'h81, 8'h00, 8);
        waitDrain(10);
        checkOutput("sameCycleNoDrop", dropSeen - dropBase, 0);

        $display("[TB] flush pending behind a full buffer");
        word_ready_i = 1'b0;
        pushWord(8'h96, 8, 1'b0);
        pushWord(8'h05, 3, 1'b0);
        driveWord(8'h96, 8'h00, 8);
        driveWord(8'h05, 8'h00, 3);
        driveCycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        checkOutput("pendingBufData", int'(word_data_o), 'h96);
        word_ready_i = 1'b1;
        waitDrain(10);
        idle(3);
        checkOutput("pendingNoExtra", int'(word_valid_o), 0);

        $display("[TB] flush while holding a full word");
        word_ready_i = 1'b0;
        pushWord(8'h0F, 8, 1'b0);
        pushWord(8'hF0, 8, 1'b0);
        driveWord(8'h0F, 8'h00, 8);
        driveWord(8'hF0, 8'h00, 8);
        driveCycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        word_ready_i = 1'b1;
        waitDrain(10);
        idle(3);
        checkOutput("holdFlushNoExtra", int'(word_valid_o), 0);

        $display("[TB] five separate overflow pulses");
        pushWord(8'h00, 8, 1'b1);
        pushWord(8'h03, 2, 1'b1);
        driveWord(8'h00, 8'h55, 8);
        driveCycle(1'b1, 1'b1, 1'b1, 1'b0);
        driveCycle(1'b1, 1'b1, 1'b0, 1'b1);
        idle(1);
        waitDrain(10);
        checkOutput("ovfCntModel", int'(ovf_cnt_o), ovfModel);
`ifdef B01_OVF_COUNT_EN
        checkOutput("ovfCntSaturated", int'(ovf_cnt_o), 3);
`else
        checkOutput("ovfCntTiedOff", int'(ovf_cnt_o), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
